tile_buffer_loader: RTL and testbench

Parametrised, double-buffered tile register bank that streams weight or bias tiles from main memory into the systolic-array-facing registers. It sits between the controller's decode stage, which issues load commands, and the systolic array, which reads the active tile. It generalises the single-buffer weight and bias loaders to `NUM_CH` channels, variable tile shapes, and a variable-latency memory handshake. A tile can be prefetched into the shadow buffer while the array consumes the active one.

---
 rtl/tile_buffer_loader_if.sv | 42 ++++
 rtl/tile_buffer_loader.sv | 190 +++++++++++++++++++
 tb/tb_tile_buffer_loader.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_buffer_loader_if.sv
// Command, memory-read, swap and tile-output bundle of tile_buffer_loader.
// master = controller/memory/array side, slave = the loader itself.
interface tile_buffer_loader_if #(
    parameter int HEIGHT     = 8,
    parameter int WIDTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_CH     = 2,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic                    cmd_iv;
    logic [CH_W-1:0]         cmd_ch_id;
    logic [ADDR_WIDTH-1:0]   cmd_addr_id;
    logic [3:0]              cmd_h_id;
    logic [3:0]              cmd_w_id;
    logic                    busy_od;
    logic                    done_ov;
    logic                    err_ov;
    logic                    mem_req_ov;
    logic [ADDR_WIDTH-1:0]   mem_addr_od;
    logic                    mem_ack_iv;
    logic [DATA_WIDTH-1:0]   mem_rdata_id;
    logic [NUM_CH-1:0]       swap_iv;
    logic [NUM_CH-1:0]       ready_od;
    logic [NUM_CH-1:0][HEIGHT-1:0][WIDTH-1:0][DATA_WIDTH-1:0] tile_od;
    logic [NUM_CH-1:0][3:0]  tile_h_od;
    logic [NUM_CH-1:0][3:0]  tile_w_od;

    modport master (
        output cmd_iv, cmd_ch_id, cmd_addr_id, cmd_h_id, cmd_w_id,
        output mem_ack_iv, mem_rdata_id, swap_iv,
        input  busy_od, done_ov, err_ov, mem_req_ov, mem_addr_od,
        input  ready_od, tile_od, tile_h_od, tile_w_od
    );

    modport slave (
        input  cmd_iv, cmd_ch_id, cmd_addr_id, cmd_h_id, cmd_w_id,
        input  mem_ack_iv, mem_rdata_id, swap_iv,
        output busy_od, done_ov, err_ov, mem_req_ov, mem_addr_od,
        output ready_od, tile_od, tile_h_od, tile_w_od
    );
endinterface

// File: rtl/tile_buffer_loader.sv
// Double-buffered multi-channel tile loader: streams a row-major tile from memory into the
// shadow bank of a channel, swap makes it active. TILE_ZERO_FILL_EN clears the shadow at accept.
module tile_buffer_loader #(
    parameter int HEIGHT     = 8,
    parameter int WIDTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_CH     = 2,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               nrst,
    tile_buffer_loader_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for a load command
    // REQ   | one outstanding read per element, advance on ack
    // DONE  | publish shadow dims, raise ready for the channel
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    typedef logic [NUM_CH-1:0][1:0][HEIGHT-1:0][WIDTH-1:0][DATA_WIDTH-1:0] bank_t;

    state_t                  state_q, state_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [ADDR_WIDTH-1:0]   off_q, off_d;
    logic [3:0]              h_q, h_d, w_q, w_d;
    logic [3:0]              r_q, r_d, c_q, c_d;
    logic                    err_q, err_d;
    logic [NUM_CH-1:0]       ready_q, ready_d;
    logic [NUM_CH-1:0]       sel_q, sel_d;
    logic [NUM_CH-1:0][3:0]  sh_h_q, sh_h_d, sh_w_q, sh_w_d;
    logic [NUM_CH-1:0][3:0]  act_h_q, act_h_d, act_w_q, act_w_d;
    bank_t                   buf_q, buf_d;
    logic                    dims_ok;
    logic [NUM_CH-1:0][HEIGHT-1:0][WIDTH-1:0][DATA_WIDTH-1:0] tile_c;

    // Dimension ports are 4 bits, so HEIGHT and WIDTH must stay below 16.
    assign dims_ok = (bus.cmd_h_id != 4'd0) && (bus.cmd_h_id <= 4'(HEIGHT)) &&
                     (bus.cmd_w_id != 4'd0) && (bus.cmd_w_id <= 4'(WIDTH));

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        base_d  = base_q;
        off_d   = off_q;
        h_d     = h_q;
        w_d     = w_q;
        r_d     = r_q;
        c_d     = c_q;
        err_d   = 1'b0;
        ready_d = ready_q;
        sel_d   = sel_q;
        sh_h_d  = sh_h_q;
        sh_w_d  = sh_w_q;
        act_h_d = act_h_q;
        act_w_d = act_w_q;
        buf_d   = buf_q;

        // Swaps first, so a same-cycle accept sees the post-swap shadow bank.
        for (int k = 0; k < NUM_CH; k++) begin
            if (bus.swap_iv[k] && ready_q[k]) begin
                sel_d[k]   = ~sel_q[k];
                act_h_d[k] = sh_h_q[k];
                act_w_d[k] = sh_w_q[k];
                ready_d[k] = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.cmd_iv) begin
                    if (dims_ok) begin
                        ch_d    = bus.cmd_ch_id;
                        base_d  = bus.cmd_addr_id;
                        h_d     = bus.cmd_h_id;
                        w_d     = bus.cmd_w_id;
                        r_d     = 4'd0;
                        c_d     = 4'd0;
                        off_d   = '0;
                        state_d = REQ;
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (CH_W'(k) == bus.cmd_ch_id) begin
                                ready_d[k] = 1'b0;
`ifdef TILE_ZERO_FILL_EN
                                buf_d[k][~sel_d[k]] = '0;
`endif
                            end
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            REQ: begin
                err_d = bus.cmd_iv;
                if (bus.mem_ack_iv) begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        for (int i = 0; i < HEIGHT; i++) begin
                            for (int j = 0; j < WIDTH; j++) begin
                                if (CH_W'(k) == ch_q && r_q == 4'(i) && c_q == 4'(j)) begin
                                    buf_d[k][~sel_q[k]][i][j] = bus.mem_rdata_id;
                                end
                            end
                        end
                    end
                    off_d = off_q + 1'b1;
                    if (c_q == w_q - 4'd1) begin
                        c_d = 4'd0;
                        if (r_q == h_q - 4'd1) begin
                            state_d = DONE;
                        end else begin
                            r_d = r_q + 4'd1;
                        end
                    end else begin
                        c_d = c_q + 4'd1;
                    end
                end
            end
            DONE: begin
                err_d   = bus.cmd_iv;
                state_d = IDLE;
                for (int k = 0; k < NUM_CH; k++) begin
                    if (CH_W'(k) == ch_q) begin
                        ready_d[k] = 1'b1;
                        sh_h_d[k]  = h_q;
                        sh_w_d[k]  = w_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            base_q  <= '0;
            off_q   <= '0;
            h_q     <= '0;
            w_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            err_q   <= 1'b0;
            ready_q <= '0;
            sel_q   <= '0;
            sh_h_q  <= '0;
            sh_w_q  <= '0;
            act_h_q <= '0;
            act_w_q <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            base_q  <= base_d;
            off_q   <= off_d;
            h_q     <= h_d;
            w_q     <= w_d;
            r_q     <= r_d;
            c_q     <= c_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            sel_q   <= sel_d;
            sh_h_q  <= sh_h_d;
            sh_w_q  <= sh_w_d;
            act_h_q <= act_h_d;
            act_w_q <= act_w_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        tile_c = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            tile_c[k] = buf_q[k][sel_q[k]];
        end
    end

    // Running offset equals r*w + c because elements are fetched in row-major order.
    assign bus.busy_od     = (state_q != IDLE);
    assign bus.done_ov     = (state_q == DONE);
    assign bus.err_ov      = err_q;
    assign bus.mem_req_ov  = (state_q == REQ);
    assign bus.mem_addr_od = (state_q == REQ) ? (base_q + off_q) : '0;
    assign bus.ready_od    = ready_q;
    assign bus.tile_od     = tile_c;
    assign bus.tile_h_od   = act_h_q;
    assign bus.tile_w_od   = act_w_q;
endmodule

// File: tb/tb_tile_buffer_loader.sv
// Scoreboard bench for tile_buffer_loader: expected addresses queued at command issue,
// checked by a variable-latency memory responder; tile contents checked against a bank model.
module tb_tile_buffer_loader;
    localparam int H = 8, W = 8, DW = 8, AW = 10, NC = 2;

    logic clk, nrst;
    tile_buffer_loader_if #(.HEIGHT(H), .WIDTH(W), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC)) bus ();

    tile_buffer_loader #(.HEIGHT(H), .WIDTH(W), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC))
        dut (.clk(clk), .nrst(nrst), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0, n_pass = 0;
    logic [AW-1:0] addr_q[$];
    int gap_max = 0, acks = 0;
    logic [7:0] seed = 8'h00;

    logic [7:0] bank_m [NC][2][H][W];
    logic [NC-1:0] sel_m, ready_m;
    logic [3:0] shh_m [NC], shw_m [NC], acth_m [NC], actw_m [NC];
    int cur_ch;
    logic [3:0] cur_h, cur_w;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
        logic [AW-1:0] t;
        t = a * 10'd13 + {2'b00, seed};
        return t[7:0] ^ {6'b0, a[9:8]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < H; i++)
                    for (int j = 0; j < W; j++) bank_m[k][b][i][j] = 8'h00;
            shh_m[k] = 0; shw_m[k] = 0; acth_m[k] = 0; actw_m[k] = 0;
        end
        sel_m = '0;
        ready_m = '0;
    endtask

    task automatic check_tile(input int ch);
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++)
                chk($sformatf("tile%0d_%0d_%0d", ch, i, j), bus.tile_od[ch][i][j],
                    bank_m[ch][sel_m[ch]][i][j]);
    endtask

    task automatic check_dims();
        for (int k = 0; k < NC; k++) begin
            chk($sformatf("tile_h%0d", k), bus.tile_h_od[k], acth_m[k]);
            chk($sformatf("tile_w%0d", k), bus.tile_w_od[k], actw_m[k]);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"}, bus.busy_od, 0);
        chk({tag, "_done"}, bus.done_ov, 0);
        chk({tag, "_err"}, bus.err_ov, 0);
        chk({tag, "_req"}, bus.mem_req_ov, 0);
        chk({tag, "_addr"}, bus.mem_addr_od, 0);
        chk({tag, "_ready"}, bus.ready_od, 0);
        check_dims();
        for (int k = 0; k < NC; k++) check_tile(k);
    endtask

    task automatic send_cmd(input int ch, input logic [AW-1:0] a, input logic [3:0] h,
                            input logic [3:0] w, input bit exp_err);
        logic [1:0] sh;
        @(posedge clk); #1;
        bus.cmd_iv = 1'b1;
        bus.cmd_ch_id = 1'(ch);
        bus.cmd_addr_id = a;
        bus.cmd_h_id = h;
        bus.cmd_w_id = w;
        if (!exp_err) begin
            cur_ch = ch; cur_h = h; cur_w = w;
            ready_m[ch] = 1'b0;
            sh = {1'b0, ~sel_m[ch]};
`ifdef TILE_ZERO_FILL_EN
            for (int i = 0; i < H; i++)
                for (int j = 0; j < W; j++) bank_m[ch][sh[0]][i][j] = 8'h00;
`endif
            for (int i = 0; i < int'(h); i++)
                for (int j = 0; j < int'(w); j++) begin
                    bank_m[ch][sh[0]][i][j] = mem_byte(a + AW'(i * int'(w) + j));
                    addr_q.push_back(a + AW'(i * int'(w) + j));
                end
        end
        @(posedge clk); #1;
        bus.cmd_iv = 1'b0;
        chk("err_pulse", bus.err_ov, exp_err);
        if (exp_err) begin
            @(posedge clk); #1;
            chk("err_once", bus.err_ov, 0);
        end
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 1;
        while (!bus.done_ov && cyc < limit) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_seen", bus.done_ov, 1);
        chk("busy_in_done", bus.busy_od, 1);
        chk("ready_in_done", bus.ready_od, ready_m);
        ready_m[cur_ch] = 1'b1;
        shh_m[cur_ch] = cur_h;
        shw_m[cur_ch] = cur_w;
        @(posedge clk); #1;
        chk("done_one_cycle", bus.done_ov, 0);
        chk("idle_after_done", bus.busy_od, 0);
        chk("ready_after_done", bus.ready_od, ready_m);
        chk("queue_drained", addr_q.size(), 0);
    endtask

    task automatic do_swap(input logic [NC-1:0] s);
        @(posedge clk); #1;
        chk("ready_pre_swap", bus.ready_od, ready_m);
        bus.swap_iv = s;
        for (int k = 0; k < NC; k++)
            if (s[k] && ready_m[k]) begin
                sel_m[k] = ~sel_m[k];
                acth_m[k] = shh_m[k];
                actw_m[k] = shw_m[k];
                ready_m[k] = 1'b0;
            end
        @(posedge clk); #1;
        bus.swap_iv = '0;
        chk("ready_post_swap", bus.ready_od, ready_m);
        check_dims();
    endtask

    // Memory responder: random gap before each ack, address must hold while waiting.
    initial begin
        logic [AW-1:0] prev;
        bit have_prev;
        int gap;
        have_prev = 0;
        gap = 0;
        bus.mem_ack_iv = 1'b0;
        bus.mem_rdata_id = '0;
        forever begin
            @(posedge clk); #2;
            bus.mem_ack_iv = 1'b0;
            if (!nrst) begin
                have_prev = 0;
                gap = 0;
            end else if (bus.mem_req_ov) begin
                if (have_prev) chk("addr_stable", bus.mem_addr_od, prev);
                if (gap > 0) begin
                    gap--;
                    prev = bus.mem_addr_od;
                    have_prev = 1;
                end else begin
                    if (addr_q.size() == 0) chk("unexpected_req", 1, 0);
                    else chk("mem_addr", bus.mem_addr_od, addr_q.pop_front());
                    bus.mem_ack_iv = 1'b1;
                    bus.mem_rdata_id = mem_byte(bus.mem_addr_od);
                    have_prev = 0;
                    gap = $urandom_range(0, gap_max);
                    acks++;
                end
            end else begin
                have_prev = 0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int cyc, n;
        logic [7:0] a33;
        nrst = 1'b0;
        bus.cmd_iv = 1'b0;
        bus.cmd_ch_id = '0;
        bus.cmd_addr_id = '0;
        bus.cmd_h_id = '0;
        bus.cmd_w_id = '0;
        bus.swap_iv = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        nrst = 1'b1;

        // 2x3 tile with ack every cycle
        gap_max = 0;
        seed = 8'h11;
        send_cmd(0, 10'h100, 4'd2, 4'd3, 1'b0);
        chk("first_req", bus.mem_req_ov, 1);
        chk("first_addr", bus.mem_addr_od, 10'h100);
        wait_done(200, cyc);
        chk("done_latency", cyc, 7);
        chk("ready_01", bus.ready_od, 2'b01);
        do_swap(2'b01);
        chk("tile_0_1_2", bus.tile_od[0][1][2], mem_byte(10'h105));
        chk("dim_h_2", bus.tile_h_od[0], 2);
        chk("dim_w_3", bus.tile_w_od[0], 3);
        check_tile(0);

        // 4x4 with random ack gaps, a command while busy, then illegal dims
        gap_max = 3;
        seed = 8'h5a;
        send_cmd(0, 10'h040, 4'd4, 4'd4, 1'b0);
        send_cmd(1, 10'h3f0, 4'd1, 4'd1, 1'b1);
        wait_done(400, cyc);
        do_swap(2'b01);
        check_tile(0);
        send_cmd(0, 10'h000, 4'd0, 4'd2, 1'b1);
        send_cmd(1, 10'h000, 4'd3, 4'd9, 1'b1);
        chk("idle_after_err", bus.busy_od, 0);

        // ch1 loads while ch0 active; early swap of ch1 is ignored
        seed = 8'hc3;
        send_cmd(1, 10'h200, 4'd3, 4'd5, 1'b0);
        do_swap(2'b10);
        check_tile(0);
        check_tile(1);
        wait_done(400, cyc);
        check_tile(0);
        do_swap(2'b10);
        check_tile(1);
        check_tile(0);

        // stale vs zero-filled contents outside a small tile
        nrst = 1'b0;
        #1;
        model_reset();
        @(posedge clk); #1;
        nrst = 1'b1;
        gap_max = 1;
        seed = 8'h21;
        a33 = mem_byte(10'd27);
        send_cmd(0, 10'h000, 4'd8, 4'd8, 1'b0);
        wait_done(800, cyc);
        do_swap(2'b01);
        seed = 8'h77;
        send_cmd(0, 10'h080, 4'd8, 4'd8, 1'b0);
        wait_done(800, cyc);
        do_swap(2'b01);
        seed = 8'h9e;
        send_cmd(0, 10'h300, 4'd2, 4'd2, 1'b0);
        wait_done(200, cyc);
        do_swap(2'b01);
        check_tile(0);
`ifdef TILE_ZERO_FILL_EN
        chk("elem_3_3_fill", bus.tile_od[0][3][3], 8'h00);
`else
        chk("elem_3_3_stale", bus.tile_od[0][3][3], a33);
`endif

        // reset during REQ at element 5, then a clean restart
        gap_max = 0;
        seed = 8'h3c;
        acks = 0;
        send_cmd(1, 10'h0a0, 4'd4, 4'd4, 1'b0);
        n = 0;
        while (acks < 5 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("acks_before_reset", acks, 5);
        chk("req_at_elem5", bus.mem_addr_od, 10'h0a5);
        nrst = 1'b0;
        #1;
        addr_q.delete();
        model_reset();
        check_reset_state("midreset");
        @(posedge clk); #1;
        nrst = 1'b1;
        seed = 8'h48;
        send_cmd(1, 10'h1c0, 4'd2, 4'd2, 1'b0);
        chk("restart_addr", bus.mem_addr_od, 10'h1c0);
        wait_done(200, cyc);
        chk("restart_latency", cyc, 5);
        do_swap(2'b10);
        check_tile(1);
        check_tile(0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
